// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state codes,
// opcode constants, ALU operation encodings and the control word layout.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // instr[31:26] values recognised by the decoder
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALUop encodings, also consumed by ALU_Ctrl
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand mux selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    // True for every opcode that has its own execution path
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the control FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, mem_ready, zero,
        output PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUop, PCSource, state, illegal
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
               ALUSrcB, ALUop, PCSource, state, illegal
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of the current state into the control word.
// Only IF looks at mem_ready: the IR and PC are written in the cycle the
// fetch completes.
module ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state control values; everything not named stays 0
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_ID: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, lw/sw flag and next-state
// logic; output decode lives in ctrl_decode.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_t state_q, state_d;
    logic   is_lw_q, is_lw_d;
    ctrl_t  ctrl;

    // Next state; the opcode is only looked at in ID, where the lw/sw
    // choice is latched so MEM_ADDR does not depend on the IR later on
    always_comb begin
        state_d = state_q;
        is_lw_d = is_lw_q;
        unique case (state_q)
            S_IF:       state_d = bus.mem_ready ? S_ID : S_IF;
            S_ID: begin
                is_lw_d = (bus.opcode == OP_LW);
                if (bus.opcode == OP_R)
                    state_d = S_R_EX;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                    state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_BEQ)
                    state_d = S_BEQ;
                else if (bus.opcode == OP_J)
                    state_d = S_JMP;
                else if (bus.opcode == OP_ADDI)
                    state_d = S_ADDI_EX;
                else
                    state_d = ILLEGAL_TRAP ? S_TRAP : S_IF;
            end
            S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_IF;
            S_MEM_WR:   state_d = bus.mem_ready ? S_IF : S_MEM_WR;
            S_R_EX:     state_d = S_R_WB;
            S_R_WB:     state_d = S_IF;
            S_BEQ:      state_d = S_IF;
            S_JMP:      state_d = S_IF;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_IF;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IF;
        endcase
    end

    // State register; reset wins over every transition including TRAP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.pc_en       = ctrl.pc_write | (ctrl.pc_write_cond & bus.zero);
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUop       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.state       = state_q;
    assign bus.illegal     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (trap on / trap off)
// share the stimulus; expected state and control vectors are queued when a
// cycle is driven and compared against the outputs before the next edge.
module tb_multicycle_ctrl;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st1;
        logic [3:0] st0;
        logic       mr;
        logic       z;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus1 ();
    multicycle_ctrl_if bus0 ();

    assign bus1.opcode    = opcode;
    assign bus1.mem_ready = mem_ready;
    assign bus1.zero      = zero;
    assign bus0.opcode    = opcode;
    assign bus0.mem_ready = mem_ready;
    assign bus0.zero      = zero;

    multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // {state, PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, MemtoReg,
    //  IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal}
    wire [21:0] obs1 = {bus1.state, bus1.PCWrite, bus1.PCWriteCond, bus1.pc_en,
                        bus1.IorD, bus1.MemRead, bus1.MemWrite, bus1.MemtoReg,
                        bus1.IRWrite, bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA,
                        bus1.ALUSrcB, bus1.ALUop, bus1.PCSource, bus1.illegal};
    wire [21:0] obs0 = {bus0.state, bus0.PCWrite, bus0.PCWriteCond, bus0.pc_en,
                        bus0.IorD, bus0.MemRead, bus0.MemWrite, bus0.MemtoReg,
                        bus0.IRWrite, bus0.RegDst, bus0.RegWrite, bus0.ALUSrcA,
                        bus0.ALUSrcB, bus0.ALUop, bus0.PCSource, bus0.illegal};

    // Control table written out from the state descriptions
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr, input logic z);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill, pe;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            4'd9:  begin pcw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd12: ill = 1;
            default: ;
        endcase
        pe = pcw | (pcwc & z);
        return {st, pcw, pcwc, pe, iord, mrd, mwr, m2r, irw, rdst, rw, asa,
                asb, aop, psrc, ill};
    endfunction

    // One clock: drive inputs, queue the expectation, compare mid-cycle
    task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                       input logic z, input logic [3:0] es1, input logic [3:0] es0,
                       input string tag);
        exp_t e;
        logic [21:0] x1, x0;
        rst = r; opcode = op; mem_ready = mr; zero = z;
        sb.push_back('{st1: es1, st0: es0, mr: mr, z: z});
        #2;
        e  = sb.pop_front();
        x1 = exp_vec(e.st1, e.mr, e.z);
        x0 = exp_vec(e.st0, e.mr, e.z);
        checks++;
        assert (obs1 === x1) else begin
            errors++;
            $error("FAIL %s trap1 got %h expected %h", tag, obs1, x1);
        end
        checks++;
        assert (obs0 === x0) else begin
            errors++;
            $error("FAIL %s trap0 got %h expected %h", tag, obs0, x0);
        end
        $display("cycle %-10s op=%b mr=%0b z=%0b st1=%0d st0=%0d", tag, op, mr, z, bus1.state, bus0.state);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = R; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = J; ops[5] = ADDI;

        rst = 1'b1; opcode = R; mem_ready = 1'b1; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state and R-type: 0,1,6,7,0
        cyc(0, R, 1, 0, 0, 0, "r_if");
        cyc(0, R, 1, 0, 1, 1, "r_id");
        cyc(0, R, 1, 0, 6, 6, "r_ex");
        cyc(0, R, 1, 0, 7, 7, "r_wb");

        // lw with memory stalling three cycles
        cyc(0, LW, 1, 0, 0, 0, "lw_if");
        cyc(0, LW, 1, 0, 1, 1, "lw_id");
        cyc(0, LW, 1, 0, 2, 2, "lw_addr");
        cyc(0, LW, 0, 0, 3, 3, "lw_rd0");
        cyc(0, LW, 0, 0, 3, 3, "lw_rd1");
        cyc(0, LW, 0, 0, 3, 3, "lw_rd2");
        cyc(0, LW, 1, 0, 3, 3, "lw_rd3");
        cyc(0, LW, 1, 0, 4, 4, "lw_wb");

        // fetch stall then beq taken / not taken
        cyc(0, BEQ, 0, 1, 0, 0, "beq_stall");
        cyc(0, BEQ, 1, 1, 0, 0, "beq_if");
        cyc(0, BEQ, 1, 1, 1, 1, "beq_id");
        cyc(0, BEQ, 1, 1, 8, 8, "beq_taken");
        cyc(0, BEQ, 1, 0, 0, 0, "beqn_if");
        cyc(0, BEQ, 1, 0, 1, 1, "beqn_id");
        cyc(0, BEQ, 1, 0, 8, 8, "beq_not");

        // jump and addi
        cyc(0, J, 1, 0, 0, 0, "j_if");
        cyc(0, J, 1, 0, 1, 1, "j_id");
        cyc(0, J, 1, 0, 9, 9, "j_jmp");
        cyc(0, ADDI, 1, 0, 0, 0, "addi_if");
        cyc(0, ADDI, 1, 0, 1, 1, "addi_id");
        cyc(0, ADDI, 1, 0, 10, 10, "addi_ex");
        cyc(0, ADDI, 1, 0, 11, 11, "addi_wb");

        // sw completing normally
        cyc(0, SW, 1, 0, 0, 0, "sw_if");
        cyc(0, SW, 1, 0, 1, 1, "sw_id");
        cyc(0, SW, 1, 0, 2, 2, "sw_addr");
        cyc(0, SW, 1, 0, 5, 5, "sw_wr");

        // unknown opcode: trap instance sticks, other returns to IF
        cyc(0, BAD, 1, 0, 0, 0, "bad_if");
        cyc(0, BAD, 1, 0, 1, 1, "bad_id");
        for (int i = 0; i < 10; i++)
            cyc(0, BAD, 0, 0, 12, 0, "trap_hold");
        cyc(1, BAD, 0, 0, 12, 0, "trap_rst");
        cyc(0, R, 0, 0, 0, 0, "after_rst");

        // sw interrupted by reset while waiting in MEM_WR
        cyc(0, SW, 1, 0, 0, 0, "swr_if");
        cyc(0, SW, 1, 0, 1, 1, "swr_id");
        cyc(0, SW, 1, 0, 2, 2, "swr_addr");
        cyc(1, SW, 0, 0, 5, 5, "swr_wr_rst");
        cyc(0, SW, 0, 0, 0, 0, "swr_after");

        // random legal program: mutual-exclusion invariants
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            opcode    = ops[$urandom_range(0, 5)];
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            #2;
            checks++;
            assert ((bus1.MemRead & bus1.MemWrite) === 1'b0) else begin
                errors++;
                $error("FAIL rnd_mem1 got %0b expected 0", bus1.MemRead & bus1.MemWrite);
            end
            checks++;
            assert ((bus1.RegWrite & (bus1.PCWrite | bus1.PCWriteCond)) === 1'b0) else begin
                errors++;
                $error("FAIL rnd_wr1 got 1 expected 0");
            end
            checks++;
            assert ((bus0.MemRead & bus0.MemWrite) === 1'b0) else begin
                errors++;
                $error("FAIL rnd_mem0 got %0b expected 0", bus0.MemRead & bus0.MemWrite);
            end
            checks++;
            assert ((bus0.RegWrite & (bus0.PCWrite | bus0.PCWriteCond)) === 1'b0) else begin
                errors++;
                $error("FAIL rnd_wr0 got 1 expected 0");
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
